// File: rtl/debug_trace_unit.sv
// rtl/debug_trace_unit.sv - run-controlled CPU trace unit dumping PC, register file and data memory as a record stream
module debug_trace_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cycle_limit,
    input  logic                         step_mode,
    input  logic                         halt_req,
    output logic                         cpu_en,
    input  logic [DATA_W-1:0]            pc_in,
    output logic [$clog2(NUM_REGS)-1:0]  rf_addr,
    input  logic [DATA_W-1:0]            rf_data,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [1:0]                   out_tag,
    output logic [7:0]                   out_index,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             cycle_count
);

    localparam int RA_W = $clog2(NUM_REGS);
    localparam int MA_W = $clog2(MEM_WORDS);

    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;
    localparam logic [1:0] TAG_END = 2'd3;

    localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);
    localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cycle_count_q;
    logic [CNT_W-1:0]   limit_q;
    logic               step_q;
    // Set by a halt (in RUN or DUMP) or by reaching the limit: end of dump goes to DONE
    logic               stop_q;

    // Loader pointer: which record is fetched next, and whether any remain
    logic [1:0]         ld_tag_q;
    logic [7:0]         ld_idx_q;
    logic               ld_pend_q;

    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [1:0]         out_tag_q;
    logic [7:0]         out_index_q;

    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  rec_data_d;
    logic               limit_hit;
    logic               load_en;
    logic               end_acc;

    assign cpu_en      = (state_q == S_RUN) && !halt_req;
    assign busy        = (state_q == S_RUN) || (state_q == S_DUMP);
    assign done        = (state_q == S_DONE);
    assign cycle_count = cycle_count_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_index   = out_index_q;

    // Saturating cycle counter; limit compare done one bit wider so all-ones never wraps into a match
    assign cnt_d     = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    assign limit_hit = (limit_q != '0) &&
                       (({1'b0, cycle_count_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, limit_q});

    assign load_en = (state_q == S_DUMP) && ld_pend_q && (!out_valid_q || out_ready);
    assign end_acc = (state_q == S_DUMP) && out_valid_q && out_ready && (out_tag_q == TAG_END);

    assign rf_addr  = (ld_tag_q == TAG_REG) ? ld_idx_q[RA_W-1:0] : '0;
    assign mem_addr = (ld_tag_q == TAG_MEM) ? ld_idx_q[MA_W-1:0] : '0;

    // Payload of the record currently addressed by the loader
    always_comb begin
        rec_data_d = '0;
        unique case (ld_tag_q)
            TAG_PC:  rec_data_d = pc_in;
            TAG_REG: rec_data_d = rf_data;
            TAG_MEM: rec_data_d = mem_data;
            default: rec_data_d = DATA_W'(cycle_count_q);
        endcase
    end

    // Control FSM with run counter, dump loader and output record register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cycle_count_q <= '0;
            limit_q       <= '0;
            step_q        <= 1'b0;
            stop_q        <= 1'b0;
            ld_tag_q      <= TAG_PC;
            ld_idx_q      <= '0;
            ld_pend_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_index_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_RUN;
                        cycle_count_q <= '0;
                        limit_q       <= cycle_limit;
                        step_q        <= step_mode;
                        stop_q        <= 1'b0;
                    end
                end
                S_RUN: begin
                    ld_tag_q  <= TAG_PC;
                    ld_idx_q  <= '0;
                    ld_pend_q <= 1'b1;
                    if (halt_req) begin
                        state_q <= S_DUMP;
                        stop_q  <= 1'b1;
                    end else begin
                        cycle_count_q <= cnt_d;
                        if (limit_hit) begin
                            state_q <= S_DUMP;
                            stop_q  <= 1'b1;
                        end else if (step_q) begin
                            state_q <= S_DUMP;
                        end
                    end
                end
                S_DUMP: begin
                    if (halt_req) begin
                        stop_q <= 1'b1;
                    end
                    if (load_en) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rec_data_d;
                        out_tag_q   <= ld_tag_q;
                        out_index_q <= ((ld_tag_q == TAG_REG) || (ld_tag_q == TAG_MEM)) ? ld_idx_q : 8'd0;
                        unique case (ld_tag_q)
                            TAG_PC: begin
                                ld_tag_q <= TAG_REG;
                                ld_idx_q <= '0;
                            end
                            TAG_REG: begin
                                if (ld_idx_q == LAST_REG) begin
                                    ld_tag_q <= TAG_MEM;
                                    ld_idx_q <= '0;
                                end else begin
                                    ld_idx_q <= ld_idx_q + 8'd1;
                                end
                            end
                            TAG_MEM: begin
                                if (ld_idx_q == LAST_MEM) begin
                                    ld_tag_q <= TAG_END;
                                    ld_idx_q <= '0;
                                end else begin
                                    ld_idx_q <= ld_idx_q + 8'd1;
                                end
                            end
                            default: ld_pend_q <= 1'b0;
                        endcase
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (end_acc) begin
                        out_valid_q <= 1'b0;
                        state_q     <= (stop_q || halt_req || !step_q) ? S_DONE : S_RUN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_trace_unit.sv
// tb/tb_debug_trace_unit.sv - scoreboard bench for debug_trace_unit
module tb_debug_trace_unit;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;
    localparam int MEM_WORDS = 8;
    localparam int CNT_W     = 16;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         start;
    logic [CNT_W-1:0]             cycle_limit;
    logic                         step_mode;
    logic                         halt_req;
    logic                         cpu_en;
    logic [DATA_W-1:0]            pc_in;
    logic [$clog2(NUM_REGS)-1:0]  rf_addr;
    logic [DATA_W-1:0]            rf_data;
    logic [$clog2(MEM_WORDS)-1:0] mem_addr;
    logic [DATA_W-1:0]            mem_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    logic [1:0]                   out_tag;
    logic [7:0]                   out_index;
    logic                         busy;
    logic                         done;
    logic [CNT_W-1:0]             cycle_count;

    typedef struct packed {
        logic [1:0]        tag;
        logic [7:0]        index;
        logic [DATA_W-1:0] data;
    } rec_t;

    rec_t sb[$];
    rec_t mon_got;
    rec_t mon_exp;
    rec_t held;
    bit   stall_prev = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int acc_cnt  = 0;
    int first_acc = 0;
    int last_acc  = 0;
    int reg1_seen = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(int i);
        return (i == 1) ? 32'd10 : (32'hA000_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] mem_val(int i);
        return 32'hB000_0000 | 32'(i);
    endfunction

    assign rf_data  = rf_val(int'(rf_addr));
    assign mem_data = mem_val(int'(mem_addr));

    debug_trace_unit #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cycle_limit(cycle_limit),
        .step_mode(step_mode), .halt_req(halt_req), .cpu_en(cpu_en), .pc_in(pc_in),
        .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_index(out_index), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr_counts();
        en_cnt    = 0;
        acc_cnt   = 0;
        reg1_seen = 0;
    endtask

    task automatic push_dump(input logic [31:0] pc, input logic [31:0] end_val);
        sb.push_back('{tag: 2'd0, index: 8'd0, data: pc});
        for (int i = 0; i < NUM_REGS; i++) sb.push_back('{tag: 2'd1, index: 8'(i), data: rf_val(i)});
        for (int i = 0; i < MEM_WORDS; i++) sb.push_back('{tag: 2'd2, index: 8'(i), data: mem_val(i)});
        sb.push_back('{tag: 2'd3, index: 8'd0, data: end_val});
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("done reached", 64'(done), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall stability, record scoreboard, cpu_en pulse count
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (cpu_en) en_cnt++;
            if (stall_prev) begin
                check("stall valid held", 64'(out_valid), 64'd1);
                check("stall record held", 64'({out_tag, out_index, out_data}), 64'(held));
            end
            if (out_valid && out_ready) begin
                mon_got = '{tag: out_tag, index: out_index, data: out_data};
                acc_cnt++;
                if (acc_cnt == 1) first_acc = cyc;
                last_acc = cyc;
                if (mon_got.tag == 2'd1 && mon_got.index == 8'd1 && mon_got.data == 32'd10) reg1_seen++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected record: got %0h expected none", mon_got);
                end else begin
                    mon_exp = sb.pop_front();
                    check("record", 64'(mon_got), 64'(mon_exp));
                end
            end
            stall_prev = out_valid && !out_ready;
            held = '{tag: out_tag, index: out_index, data: out_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; cycle_limit = '0; step_mode = 1'b0;
        halt_req = 1'b0; out_ready = 1'b1; pc_in = 32'h0000_1000;
        tick(); tick();
        check("rst cpu_en", 64'(cpu_en), 0);
        check("rst out_valid", 64'(out_valid), 0);
        check("rst busy", 64'(busy), 0);
        check("rst done", 64'(done), 0);
        check("rst cycle_count", 64'(cycle_count), 0);
        check("rst out_data", 64'(out_data), 0);
        check("rst out_tag", 64'(out_tag), 0);
        check("rst out_index", 64'(out_index), 0);
        check("rst rf_addr", 64'(rf_addr), 0);
        check("rst mem_addr", 64'(mem_addr), 0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle cpu_en", 64'(cpu_en), 0);
        check("idle out_valid", 64'(out_valid), 0);
        check("idle busy", 64'(busy), 0);
        check("idle done", 64'(done), 0);

        // Limit 5, no stepping
        clr_counts();
        pc_in = 32'h0000_1000;
        push_dump(pc_in, 32'd5);
        cycle_limit = 16'd5; step_mode = 1'b0;
        pulse_start();
        wait_done(400);
        check("lim5 cpu_en cycles", 64'(en_cnt), 64'd5);
        check("lim5 records", 64'(acc_cnt), 64'd42);
        check("lim5 back-to-back", 64'(last_acc - first_acc), 64'd41);
        check("lim5 sb empty", 64'(sb.size()), 0);
        check("lim5 count", 64'(cycle_count), 64'd5);
        check("lim5 busy", 64'(busy), 0);

        // Limit 5, step mode
        clr_counts();
        pc_in = 32'h0000_2000;
        for (int k = 1; k <= 5; k++) push_dump(pc_in, 32'(k));
        cycle_limit = 16'd5; step_mode = 1'b1;
        pulse_start();
        wait_done(2000);
        check("step cpu_en cycles", 64'(en_cnt), 64'd5);
        check("step records", 64'(acc_cnt), 64'd210);
        check("step sb empty", 64'(sb.size()), 0);

        // Backpressure with out_ready toggling
        clr_counts();
        pc_in = 32'h0000_2500;
        push_dump(pc_in, 32'd1);
        cycle_limit = 16'd1; step_mode = 1'b0;
        pulse_start();
        n = 0;
        while (!done && n < 800) begin
            out_ready = ~out_ready;
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("bp done", 64'(done), 64'd1);
        check("bp reg1 seen once", 64'(reg1_seen), 64'd1);
        check("bp records", 64'(acc_cnt), 64'd42);
        check("bp sb empty", 64'(sb.size()), 0);

        // Unlimited run stopped by halt in the 4th RUN cycle
        clr_counts();
        pc_in = 32'h0000_3000;
        push_dump(pc_in, 32'd3);
        cycle_limit = 16'd0; step_mode = 1'b0;
        pulse_start();
        tick(); tick(); tick();
        halt_req = 1'b1;
        @(negedge clk);
        check("halt cpu_en low", 64'(cpu_en), 0);
        check("halt busy", 64'(busy), 64'd1);
        tick();
        halt_req = 1'b0;
        wait_done(400);
        check("halt cpu_en cycles", 64'(en_cnt), 64'd3);
        check("halt count", 64'(cycle_count), 64'd3);
        check("halt sb empty", 64'(sb.size()), 0);

        // Reset while REG index 10 is outstanding, then restart
        clr_counts();
        pc_in = 32'h0000_4000;
        push_dump(pc_in, 32'd2);
        cycle_limit = 16'd2; step_mode = 1'b0;
        pulse_start();
        n = 0;
        while (!(out_valid && out_tag == 2'd1 && out_index == 8'd10) && n < 300) begin
            tick();
            n++;
        end
        check("reach reg10", 64'(out_valid && out_tag == 2'd1 && out_index == 8'd10), 64'd1);
        out_ready = 1'b0;
        reset = 1'b0;
        tick();
        check("midrst out_valid", 64'(out_valid), 0);
        check("midrst busy", 64'(busy), 0);
        check("midrst done", 64'(done), 0);
        check("midrst count", 64'(cycle_count), 0);
        check("midrst remaining", 64'(sb.size()), 64'd31);
        sb.delete();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        clr_counts();
        pc_in = 32'h0000_4100;
        push_dump(pc_in, 32'd2);
        pulse_start();
        check("restart count", 64'(cycle_count), 0);
        wait_done(400);
        check("restart cpu_en cycles", 64'(en_cnt), 64'd2);
        check("restart records", 64'(acc_cnt), 64'd42);
        check("restart sb empty", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
